sub_serial: RTL and testbench
=============================

SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (min 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: en  input  1  level start request; also serves as release acknowledge in DONE.
REQ-005 SHALL have port: a  input  WIDTH  minuend; sampled only on start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend; sampled only on start.
REQ-007 SHALL have port: out  output  WIDTH  difference a-b mod 2^WIDTH; registered.
REQ-008 SHALL have port: borrow  output  1  final borrow (1 when a<b unsigned); registered.
REQ-009 SHALL have port: busy  output  1  high in SUB.
REQ-010 SHALL have port: done  output  1  high in DONE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SUB, DONE.
REQ-012 In IDLE with en=1, SHALL:
- load a_reg<=a and b_reg<=b;
- clear out, borrow and count;
- enter SUB next cycle.
REQ-013 In IDLE with en=0, SHALL hold all registers.
REQ-014 Each SUB cycle SHALL compute:
- d = a_reg[0]^b_reg[0]^borrow;
- borrow <= (~a_reg[0]&b_reg[0]) | (~a_reg[0]&borrow) | (b_reg[0]&borrow);
- out <= {d, out[WIDTH-1:1]};
- a_reg and b_reg logical right shift by 1;
- count <= count+1.
REQ-015 count SHALL be $clog2(WIDTH) bits wide.
REQ-016 SUB SHALL last exactly WIDTH cycles, leaving for DONE when count==WIDTH-1.
REQ-017 Latency SHALL be WIDTH+1 cycles from the en-sampling edge to the first cycle with done=1.
REQ-018 In DONE, out and borrow SHALL hold stable.
REQ-019 DONE SHALL return to IDLE on the first cycle with en=0 (four-phase handshake).
REQ-020 With en held high, the FSM SHALL stay in DONE, so a single en level never starts two operations.
REQ-021 Changes on a, b or en during SUB SHALL have no effect on the result or the timing.
REQ-022 busy and done SHALL be decoded from registered state and SHALL never both be high.
REQ-023 WIDTH=2 SHALL work; WIDTH≥2 SHALL be the only supported range.

Reset
REQ-024 rst low SHALL immediately force state=IDLE and out, borrow, a_reg, b_reg, count to 0, independent of clk.
REQ-025 Reset asserted mid-SUB SHALL abort the operation with no partial result retained.
REQ-026 After rst deassertion, the first start SHALL require en=1 sampled in IDLE.

Configuration
REQ-027 SHALL use macro SUB_SERIAL_OVF_EN.
REQ-028 With SUB_SERIAL_OVF_EN defined:
- add output port ovf (1 bit) = two's-complement signed overflow of a-b;
- ovf = (a[MSB]!=b[MSB]) & (out[MSB]!=a[MSB]), using the operand MSBs captured at start;
- ovf is valid in DONE, 0 otherwise, and 0 on reset.
REQ-029 Without SUB_SERIAL_OVF_EN, the ovf port and its capture registers SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=0x05, b=0x03, en pulse -> done after 9 cycles, out=0x02, borrow=0, ovf=0.
REQ-031 SHALL cover: a=0x03, b=0x05 -> out=0xFE, borrow=1, ovf=0.
REQ-032 SHALL cover (macro on): a=0x80, b=0x01 -> out=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> out=0x80, borrow=1, ovf=1.
REQ-033 SHALL cover: en held high 20 cycles with a=0x10, b=0x10 -> exactly one operation, out=0x00, done stays high until en=0, then IDLE.
REQ-034 SHALL cover: a/b toggled every cycle during SUB -> result equals the operands sampled at start.
REQ-035 SHALL cover: rst pulsed low at SUB cycle 4 -> out=0, busy=0, done=0 immediately; a following start gives the correct result.

Source files
------------

// File: rtl/sub_serial.sv
// Bit-serial subtractor: LSB-first ripple-borrow over WIDTH cycles, IDLE/SUB/DONE FSM.
// Optional signed-overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             busy,
    output logic             done
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count;
    logic             d;
    logic             nb;

    assign d  = a_reg[0] ^ b_reg[0] ^ borrow;
    assign nb = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);

    assign busy = (state == SUB);
    assign done = (state == DONE);

`ifdef SUB_SERIAL_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand MSBs are lost to the shift, so they are kept for the overflow test.
    assign ovf = done & (a_msb != b_msb) & (out[WIDTH-1] != a_msb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && en) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            out    <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        out    <= '0;
                        borrow <= 1'b0;
                        count  <= '0;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    out    <= {d, out[WIDTH-1:1]};
                    borrow <= nb;
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) state <= DONE;
                end
                DONE: begin
                    // Four-phase release: en must drop before a new start.
                    if (!en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=8): directed vectors, random
// operations against an arithmetic model, handshake, input-toggle and reset cases.
module tb_sub_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         borrow;
    logic         busy;
    logic         done;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .out    (out),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y) + 256) % 256;
        return r[W-1:0];
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sd;
        sd = int'($signed(x)) - int'($signed(y));
        return (sd > 127) || (sd < -128);
    endfunction

    // Starts one operation; n = edges from the sampling edge (inclusive) to done, -1 on timeout.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input bit hold, input bit toggle,
                          output int n, output bit overlap);
        @(negedge clk);
        a = ia;
        b = ib;
        en = 1'b1;
        overlap = 1'b0;
        @(posedge clk);
        n = 1;
        #1;
        if (!hold) en = 1'b0;
        while (!done && n < 40) begin
            if (busy && done) overlap = 1'b1;
            if (toggle) begin
                a = W'($urandom);
                b = W'($urandom);
                if (!hold) en = 1'($urandom);
            end
            @(posedge clk);
            n++;
            #1;
        end
        if (!done) n = -1;
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic release_op();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b0;
        a = '0;
        b = '0;
        #3;
        checks++;
        if (out !== 8'h00 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%h borrow=%b busy=%b done=%b want 00 0 0 0",
                     out, borrow, busy, done);
        end
`ifdef SUB_SERIAL_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        a = 8'h5A;
        b = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL idle_no_start busy=%b out=%h want 0 00", busy, out);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
        logic [W-1:0] vb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
        logic [W-1:0] vo [4] = '{8'h02, 8'hFE, 8'h7F, 8'h80};
        logic         vbr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         vov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int n;
        bit ov;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b0, 1'b0, n, ov);
            checks++;
            if (n != W + 1) begin
                errors++;
                $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, n, W + 1);
            end
            checks++;
            if (out !== vo[i] || borrow !== vbr[i]) begin
                errors++;
                $display("FAIL dir_result[%0d] out=%h borrow=%b want %h %b",
                         i, out, borrow, vo[i], vbr[i]);
            end
`ifdef SUB_SERIAL_OVF_EN
            checks++;
            if (ovf !== vov[i]) begin
                errors++;
                $display("FAIL dir_ovf[%0d] got=%b want=%b", i, ovf, vov[i]);
            end
`else
            if (vov[i] === 1'bx) $display("unreachable");
`endif
            release_op();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir_release[%0d] done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        int n;
        bit ov;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; end
            if (i == 1) begin ra = 8'hFF; rb = 8'hFF; end
            run_op(ra, rb, 1'($urandom), 1'b0, n, ov);
            checks++;
            if (n != W + 1 || ov) begin
                errors++;
                $display("FAIL rnd_timing[%0d] lat=%0d overlap=%0b want %0d 0", i, n, ov, W + 1);
            end
            checks++;
            if (out !== m_diff(ra, rb) || borrow !== m_borrow(ra, rb)) begin
                errors++;
                $display("FAIL rnd_result[%0d] a=%h b=%h out=%h borrow=%b want %h %b",
                         i, ra, rb, out, borrow, m_diff(ra, rb), m_borrow(ra, rb));
            end
`ifdef SUB_SERIAL_OVF_EN
            checks++;
            if (ovf !== m_ovf(ra, rb)) begin
                errors++;
                $display("FAIL rnd_ovf[%0d] a=%h b=%h got=%b want=%b", i, ra, rb, ovf, m_ovf(ra, rb));
            end
`endif
            release_op();
`ifdef SUB_SERIAL_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL rnd_ovf_idle[%0d] got=%b want 0", i, ovf);
            end
`endif
        end
    endtask

    task automatic test_hold_en();
        int n;
        bit ov;
        int bad = 0;
        run_op(8'h10, 8'h10, 1'b1, 1'b0, n, ov);
        checks++;
        if (n != W + 1 || out !== 8'h00 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL hold_result lat=%0d out=%h borrow=%b want %0d 00 0", n, out, borrow, W + 1);
        end
        for (int i = n; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1 || busy !== 1'b0 || out !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stay_done bad_cycles=%0d want 0", bad);
        end
        release_op();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_to_idle done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_toggle();
        int n;
        bit ov;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'b0, 1'b1, n, ov);
            checks++;
            if (n != W + 1 || out !== m_diff(ra, rb) || borrow !== m_borrow(ra, rb)) begin
                errors++;
                $display("FAIL toggle[%0d] lat=%0d out=%h borrow=%b want %0d %h %b",
                         i, n, out, borrow, W + 1, m_diff(ra, rb), m_borrow(ra, rb));
            end
            release_op();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ov;
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || out === 8'h00) begin
            errors++;
            $display("FAIL mid_pre busy=%b out=%h want 1 nonzero", busy, out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset out=%h borrow=%b busy=%b done=%b want 00 0 0 0",
                     out, borrow, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, n, ov);
        checks++;
        if (n != W + 1 || out !== 8'hE2 || borrow !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart lat=%0d out=%h borrow=%b want %0d e2 1", n, out, borrow, W + 1);
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_en();
        test_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
